// File: rtl/div_pkg.sv
// Shared types and constants for the sequential integer divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, iteration counts for full-width and W ops,
// and the 32-bit all-ones / most-negative patterns used by the special cases.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_t;

   // Shift-subtract iterations for a full-width op and for a W (32-bit) op.
   localparam int ITER_D = 64;
   localparam int ITER_W = 32;

   localparam logic [31:0] ONES_32 = 32'hFFFF_FFFF;
   localparam logic [31:0] MNEG_32 = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring shift-subtract iteration.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   rem, quo      partial remainder / quotient before this iteration
//   divisor       divisor magnitude
//   din           next dividend bit (MSB-first)
//   rem_nxt       partial remainder after the trial subtract
//   quo_nxt       quotient shifted left with the new bit in bit 0
module div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   input  logic            din,
   output logic [XLEN-1:0] rem_nxt,
   output logic [XLEN-1:0] quo_nxt
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          ge;
   logic          unused_msb;

   // The shifted remainder can reach 2*divisor-1, so the trial subtract is
   // carried out one bit wider than the operands.
   assign shifted = {rem, din};
   assign ge      = (shifted >= {1'b0, divisor});
   assign diff    = shifted - {1'b0, divisor};

   // When ge holds, the difference is below the divisor and fits in XLEN bits.
   assign rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign quo_nxt = {quo[XLEN-2:0], ge};

   // Quotient MSB shifts out; difference MSB is zero whenever it is selected.
   assign unused_msb = quo[XLEN-1] ^ diff[XLEN];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle divide/remainder sequencer (RISC-V div/divu/rem/remu and W forms).
// Latency: accept -> out_valid in 66 edges (full width), 34 (W), 2 (div-by-zero / overflow).
// Backpressure: single op in flight; in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready              request handshake
//   in_word/in_signed/in_rem       op select: W variant, signed, return remainder
//   in_a, in_b, in_rd              dividend, divisor, destination tag
//   flush                          abort any in-flight op (wins over accept and out_ready)
//   out_valid/out_ready            result handshake
//   out_result, out_rd             result (W forms sign-extended from bit 31), tag
//   busy                           high in every state but IDLE; core stall request
module div_seq_ctrl
   import div_pkg::*;
#(
   parameter int XLEN  = ITER_D,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_word,
   input  logic            in_signed,
   input  logic            in_rem,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [4:0]      in_rd,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            busy
);

   localparam logic [XLEN-1:0] ONES_X = '1;
   localparam logic [XLEN-1:0] MNEG_X = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             op_word;
   logic             op_signed;
   logic             op_rem;
   logic [XLEN-1:0]  dvd;       // operand as latched; MSB-aligned magnitude during CALC
   logic [XLEN-1:0]  dvs;       // divisor as latched; magnitude from PREP on
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quo_q;
   logic             q_neg;
   logic             r_neg;
   logic             spec_hit;
   logic [XLEN-1:0]  spec_res;

   logic [XLEN-1:0]  a_ext;
   logic [XLEN-1:0]  b_ext;
   logic             sa;
   logic             sb;
   logic [XLEN-1:0]  abs_a;
   logic [XLEN-1:0]  abs_b;
   logic             div_zero;
   logic             ovf;
   logic [XLEN-1:0]  fmt_dvd;
   logic [XLEN-1:0]  spec_val;
   logic [XLEN-1:0]  rem_nxt;
   logic [XLEN-1:0]  quo_nxt;
   logic [XLEN-1:0]  q_fix;
   logic [XLEN-1:0]  r_fix;
   logic [XLEN-1:0]  sel_fix;
   logic [XLEN-1:0]  res_fix;

   // W operands are narrowed at accept so PREP sees an ordinary XLEN value.
   assign a_ext = !in_word  ? in_a :
                  in_signed ? sext32(in_a[31:0]) : {{(XLEN-32){1'b0}}, in_a[31:0]};
   assign b_ext = !in_word  ? in_b :
                  in_signed ? sext32(in_b[31:0]) : {{(XLEN-32){1'b0}}, in_b[31:0]};

   assign sa    = op_signed & dvd[XLEN-1];
   assign sb    = op_signed & dvs[XLEN-1];
   assign abs_a = sa ? -dvd : dvd;
   assign abs_b = sb ? -dvs : dvs;

   // Both W special cases are visible on the extended operands: -1 extends
   // to all ones and the 32-bit most-negative extends to its XLEN image.
   assign div_zero = (dvs == '0);
   assign ovf      = op_signed && (dvs == ONES_X) &&
                     (dvd == (op_word ? sext32(MNEG_32) : MNEG_X));
   assign fmt_dvd  = op_word ? sext32(dvd[31:0]) : dvd;
   assign spec_val = div_zero ? (op_rem ? fmt_dvd : (op_word ? sext32(ONES_32) : ONES_X))
                              : (op_rem ? '0 : fmt_dvd);

   assign q_fix   = q_neg ? -quo_q : quo_q;
   assign r_fix   = r_neg ? -rem_q : rem_q;
   assign sel_fix = op_rem ? r_fix : q_fix;
   assign res_fix = op_word ? sext32(sel_fix[31:0]) : sel_fix;

   div_step #(
      .XLEN(XLEN)
   ) u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (dvs),
      .din     (dvd[XLEN-1]),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         op_word    <= 1'b0;
         op_signed  <= 1'b0;
         op_rem     <= 1'b0;
         dvd        <= '0;
         dvs        <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         spec_hit   <= 1'b0;
         spec_res   <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_rd     <= '0;
      end else if (flush && state != IDLE) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && !flush) begin
                  op_word   <= in_word;
                  op_signed <= in_signed;
                  op_rem    <= in_rem;
                  out_rd    <= in_rd;
                  dvd       <= a_ext;
                  dvs       <= b_ext;
                  state     <= PREP;
               end
            end
            PREP: begin
               // W magnitudes fit in 32 bits; left-align them so CALC always
               // pulls dividend bits from the top of dvd.
               dvd      <= op_word ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
               dvs      <= abs_b;
               rem_q    <= '0;
               quo_q    <= '0;
               q_neg    <= sa ^ sb;
               r_neg    <= sa;
               cnt      <= op_word ? CNT_W'(ITER_W - 1) : CNT_W'(XLEN - 1);
               spec_hit <= div_zero | ovf;
               spec_res <= spec_val;
               // Special cases skip CALC but still take the FIX cycle, which
               // is where out_result is loaded for every op.
               state    <= (div_zero | ovf) ? FIX : CALC;
            end
            CALC: begin
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               dvd   <= {dvd[XLEN-2:0], 1'b0};
               cnt   <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state <= FIX;
               end
            end
            FIX: begin
               out_result <= spec_hit ? spec_res : res_fix;
               out_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
